// File: rtl/batch_pkg.sv
// Shared types and constants for the batch-mode filter sequencer.
// Bank roles rotate per batch: write = cycle, lookahead = cycle-LH_OFS, compute = cycle-CB_OFS.
package batch_pkg;

  typedef logic [1:0] bank_idx_t;

  localparam bank_idx_t  LH_OFS        = 2'd1;
  localparam bank_idx_t  CB_OFS        = 2'd2;
  localparam logic [1:0] PRIME_BATCHES = 2'd2;

  function automatic logic [3:0] bank_onehot(input bank_idx_t idx);
    case (idx)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      2'd3:    return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/batch_addr_counter.sv
// Oversampling counter plus forward/reverse downsampled-word address pair.
// Also reports whether the address of the next emitted word is the first or last of a batch.
module batch_addr_counter #(
  parameter int OSR      = 2,
  parameter int DS_DEPTH = 16,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          step,
  output logic          word_done,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] addr_rev,
  output logic          next_first,
  output logic          next_last
);

  localparam int            OW        = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OW-1:0] OSR_LAST  = OW'(OSR - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DS_DEPTH - 1);

  logic [OW-1:0] osr_cnt;
  logic [AW-1:0] addr_eff;

  // addr_eff is the address the next strobe carries, accounting for an increment in flight
  always_comb begin
    word_done = in_valid && (osr_cnt == OSR_LAST);
    addr_eff  = addr;
    if (step) begin
      if (addr == ADDR_LAST) begin
        addr_eff = {AW{1'b0}};
      end else begin
        addr_eff = addr + AW'(1);
      end
    end else begin
      addr_eff = addr;
    end
    next_first = (addr_eff == {AW{1'b0}});
    next_last  = (addr_eff == ADDR_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      osr_cnt  <= {OW{1'b0}};
      addr     <= {AW{1'b0}};
      addr_rev <= ADDR_LAST;
    end else begin
      if (in_valid) begin
        osr_cnt <= (osr_cnt == OSR_LAST) ? {OW{1'b0}} : osr_cnt + OW'(1);
      end
      if (step) begin
        if (addr == ADDR_LAST) begin
          addr     <= {AW{1'b0}};
          addr_rev <= ADDR_LAST;
        end else begin
          addr     <= addr + AW'(1);
          addr_rev <= addr_rev - AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/batch_scheduler.sv
// Batch sequencer: downsample strobes, bank role rotation, recursion reset pulses and
// output-valid priming for the batch-mode control-bounded filter. Stalls on in_valid low.
module batch_scheduler
  import batch_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int OSR      = 2,
  localparam int DS_DEPTH = DEPTH / OSR,
  localparam int AW       = (DS_DEPTH > 1) ? $clog2(DS_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          ds_stb,
  output logic [AW-1:0] ds_addr,
  output logic [AW-1:0] ds_addr_rev,
  output logic [3:0]    bank_wr,
  output logic [1:0]    lh_sel,
  output logic [1:0]    cb_sel,
  output logic          pr_sel,
  output logic          lh_rst_n,
  output logic          cb_rst_n,
  output logic          batch_end,
  output logic          out_valid,
  output logic [1:0]    cycle
);

  if ((OSR < 1) || ((DEPTH % OSR) != 0)) begin : g_cfg_err
    $error("batch_scheduler: DEPTH must be a multiple of OSR and OSR >= 1");
  end

  logic       word_done;
  logic       next_first;
  logic       next_last;
  bank_idx_t  cycle_nxt;
  logic [1:0] primed;
  logic [1:0] primed_nxt;

  batch_addr_counter #(
    .OSR      (OSR),
    .DS_DEPTH (DS_DEPTH),
    .AW       (AW)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .step       (ds_stb),
    .word_done  (word_done),
    .addr       (ds_addr),
    .addr_rev   (ds_addr_rev),
    .next_first (next_first),
    .next_last  (next_last)
  );

  // Look through a pending batch_end so the role decode and out_valid see it without a bubble
  always_comb begin
    cycle_nxt  = cycle;
    primed_nxt = primed;
    if (batch_end) begin
      cycle_nxt = cycle + 2'd1;
      if (primed != PRIME_BATCHES) begin
        primed_nxt = primed + 2'd1;
      end else begin
        primed_nxt = primed;
      end
    end else begin
      cycle_nxt  = cycle;
      primed_nxt = primed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ds_stb    <= 1'b0;
      batch_end <= 1'b0;
      out_valid <= 1'b0;
      lh_rst_n  <= 1'b1;
      cb_rst_n  <= 1'b1;
      cycle     <= 2'd0;
      primed    <= 2'd0;
      bank_wr   <= 4'b0001;
      lh_sel    <= 2'd0 - LH_OFS;
      cb_sel    <= 2'd0 - CB_OFS;
      pr_sel    <= 1'b0;
    end else begin
      ds_stb    <= word_done;
      batch_end <= word_done && next_last;
      out_valid <= word_done && (primed_nxt == PRIME_BATCHES);
      lh_rst_n  <= !(word_done && next_first);
      cb_rst_n  <= !(word_done && next_first);
      cycle     <= cycle_nxt;
      primed    <= primed_nxt;
      bank_wr   <= bank_onehot(cycle_nxt);
      lh_sel    <= cycle_nxt - LH_OFS;
      cb_sel    <= cycle_nxt - CB_OFS;
      pr_sel    <= cycle_nxt[0];
    end
  end

endmodule
